// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection phase sequencer.
package traffic_pkg;

   localparam int TIMER_W = 5;

   // One-hot lamp encodings {R,Y,G}
   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   // PH_IDLE exists only between reset and the first clock edge after release.
   typedef enum logic [2:0] {
      PH_IDLE,
      PH_MAIN_G,
      PH_MAIN_Y,
      PH_SIDE_G,
      PH_SIDE_Y,
      PH_PED
   } phase_e;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_ARM,
      ST_WAIT
   } step_e;

endpackage

// File: rtl/ped_request_latch.sv
// Holds a pedestrian request until the walk phase has been served.
// Requests are blocked while the walk phase is active, so a button held
// through the walk phase does not immediately queue a second one.
module ped_request_latch (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic set_i,
   input  logic block_i,
   input  logic clear_i,
   output logic pending_o
);

   logic pending_q;
   logic pending_d;

   // Next pending state: clear wins, then set unless blocked.
   always_comb begin
      pending_d = pending_q;
      if (clear_i) begin
         pending_d = 1'b0;
      end else if (set_i && !block_i) begin
         pending_d = 1'b1;
      end
   end

   // Pending register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign pending_o = pending_q;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Phase sequencer for a two-road intersection with pedestrian crossing.
// Each phase loads the downstream countdown timer (LOAD), skips one cycle
// of stale expiry (ARM), then waits for expiry (WAIT). All outputs are
// registered from the next-state decode so they change on the phase edge.
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int T_BASE = 8,
   parameter int T_EXT  = 12,
   parameter int T_YEL  = 3,
   parameter int T_PED  = 10
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               sensor,
   input  logic               walk_request,
   input  logic               expired,
   output logic [TIMER_W-1:0] value,
   output logic               start_timer,
   output logic [2:0]         main_light,
   output logic [2:0]         side_light,
   output logic               walk
);

   localparam int T_MAX = (1 << TIMER_W) - 1;

   if (T_BASE < 1 || T_BASE > T_MAX || T_EXT < 1 || T_EXT > T_MAX ||
       T_YEL  < 1 || T_YEL  > T_MAX || T_PED < 1 || T_PED > T_MAX) begin : g_param_err
      $error("traffic_phase_ctrl: all durations must be in 1..%0d", T_MAX);
   end

   phase_e             phase_q, phase_d;
   step_e              step_q,  step_d;
   logic [TIMER_W-1:0] value_q, value_d;
   logic               start_q, start_d;
   logic [2:0]         main_q,  main_d;
   logic [2:0]         side_q,  side_d;
   logic               walk_q,  walk_d;
   logic               pending;
   logic               ped_clear;

   ped_request_latch u_ped_latch (
      .clk_i     (clock),
      .rst_ni    (reset),
      .set_i     (walk_request),
      .block_i   (phase_q == PH_PED),
      .clear_i   (ped_clear),
      .pending_o (pending)
   );

   // Duration for a phase; side green length depends on sensor at load.
   function automatic logic [TIMER_W-1:0] phase_dur(phase_e ph, logic car);
      case (ph)
         PH_MAIN_G: phase_dur = TIMER_W'(T_BASE);
         PH_SIDE_G: phase_dur = car ? TIMER_W'(T_EXT) : TIMER_W'(T_BASE);
         PH_MAIN_Y,
         PH_SIDE_Y: phase_dur = TIMER_W'(T_YEL);
         PH_PED:    phase_dur = TIMER_W'(T_PED);
         default:   phase_dur = '0;
      endcase
   endfunction

   // Next phase/sub-step and registered output decode.
   always_comb begin
      phase_d   = phase_q;
      step_d    = step_q;
      ped_clear = 1'b0;

      if (phase_q == PH_IDLE) begin
         phase_d = PH_MAIN_G;
         step_d  = ST_LOAD;
      end else begin
         case (step_q)
            ST_LOAD: step_d = ST_ARM;
            ST_ARM:  step_d = ST_WAIT;
            ST_WAIT: begin
               if (expired) begin
                  step_d = ST_LOAD;
                  case (phase_q)
                     PH_MAIN_G: phase_d = (sensor || pending) ? PH_MAIN_Y : PH_MAIN_G;
                     PH_MAIN_Y: phase_d = pending ? PH_PED : PH_SIDE_G;
                     PH_SIDE_G: phase_d = PH_SIDE_Y;
                     PH_SIDE_Y: phase_d = PH_MAIN_G;
                     PH_PED: begin
                        phase_d   = PH_MAIN_G;
                        ped_clear = 1'b1;
                     end
                     default:   phase_d = PH_MAIN_G;
                  endcase
               end
            end
            default: step_d = ST_LOAD;
         endcase
      end

      start_d = (step_d == ST_LOAD);
      value_d = value_q;
      if (step_d == ST_LOAD) begin
         value_d = phase_dur(phase_d, sensor);
      end

      main_d = RED;
      side_d = RED;
      walk_d = 1'b0;
      case (phase_d)
         PH_MAIN_G: main_d = GRN;
         PH_MAIN_Y: main_d = YEL;
         PH_SIDE_G: side_d = GRN;
         PH_SIDE_Y: side_d = YEL;
         PH_PED:    walk_d = 1'b1;
         default:   ;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         phase_q <= PH_IDLE;
         step_q  <= ST_WAIT;
         value_q <= '0;
         start_q <= 1'b0;
         main_q  <= RED;
         side_q  <= RED;
         walk_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         step_q  <= step_d;
         value_q <= value_d;
         start_q <= start_d;
         main_q  <= main_d;
         side_q  <= side_d;
         walk_q  <= walk_d;
      end
   end

   assign value       = value_q;
   assign start_timer = start_q;
   assign main_light  = main_q;
   assign side_light  = side_q;
   assign walk        = walk_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: countdown timer model (one tick per clock),
// expected phase loads queued by the stimulus, checked by a monitor on each
// start_timer pulse.
module tb_traffic_phase_ctrl;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;

   typedef struct packed {
      logic [4:0] v;
      logic [2:0] m;
      logic [2:0] s;
      logic       w;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       sensor;
   logic       walk_request;
   logic       expired;
   logic [4:0] value;
   logic       start_timer;
   logic [2:0] main_light;
   logic [2:0] side_light;
   logic       walk;

   logic       ovr;
   logic [4:0] cnt;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   pops  = 0;

   traffic_phase_ctrl #(
      .T_BASE (8),
      .T_EXT  (12),
      .T_YEL  (3),
      .T_PED  (10)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .sensor       (sensor),
      .walk_request (walk_request),
      .expired      (expired),
      .value        (value),
      .start_timer  (start_timer),
      .main_light   (main_light),
      .side_light   (side_light),
      .walk         (walk)
   );

   always #5 clock = ~clock;

   // Countdown timer model
   always @(posedge clock or negedge reset) begin
      if (!reset)           cnt <= '0;
      else if (start_timer) cnt <= value;
      else if (cnt != 0)    cnt <= cnt - 5'd1;
   end
   assign expired = ovr ? 1'b1 : (cnt == 5'd0);

   // Monitor: compare each load pulse against the queue; check lamp safety
   always @(negedge clock) begin
      if (reset === 1'b1) begin
         if (start_timer) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL load_unexpected #%0d got v=%0d m=%b s=%b w=%b, none expected",
                        pops, value, main_light, side_light, walk);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if ({value, main_light, side_light, walk} !== e) begin
                  bad++;
                  $display("FAIL load#%0d got v=%0d m=%b s=%b w=%b exp v=%0d m=%b s=%b w=%b",
                           pops, value, main_light, side_light, walk, e.v, e.m, e.s, e.w);
               end
            end
            pops++;
         end
         total++;
         if ((main_light != R && side_light != R) ||
             (walk && !(main_light == R && side_light == R))) begin
            bad++;
            $display("FAIL lamp_safety got m=%b s=%b w=%b", main_light, side_light, walk);
         end
      end
   end

   task automatic push(input logic [4:0] v, input logic [2:0] m,
                       input logic [2:0] s, input logic w);
      exp_t e;
      e.v = v; e.m = m; e.s = s; e.w = w;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, expv);
      end
   endtask

   task automatic wait_pops(input int target);
      int n = 0;
      while (pops < target && n < 400) begin
         @(posedge clock); #1;
         n++;
      end
      if (pops < target) begin
         total++;
         bad++;
         $display("FAIL wait_loads got=%0d exp=%0d", pops, target);
      end
   endtask

   task automatic count_to_load(output int n);
      n = 0;
      do begin
         @(posedge clock); #1;
         n++;
      end while (!start_timer && n < 50);
   endtask

   initial begin
      int n;
      reset = 1'b0; sensor = 1'b0; walk_request = 1'b0; ovr = 1'b0;

      // Reset state
      #12;
      chk("rst_main",  main_light,  R);
      chk("rst_side",  side_light,  R);
      chk("rst_walk",  walk,        0);
      chk("rst_start", start_timer, 0);
      chk("rst_value", value,       0);

      // 1: main green re-entry with no demand
      repeat (3) push(8, G, R, 0);
      @(negedge clock); reset = 1'b1;
      wait_pops(3);

      // 2: sensor -> side green extended, then side green normal length
      sensor = 1'b1;
      push(3, Y, R, 0); push(12, R, G, 0);
      wait_pops(5);
      sensor = 1'b0;
      push(3, R, Y, 0); push(8, G, R, 0); push(8, G, R, 0);
      wait_pops(8);
      sensor = 1'b1;
      push(3, Y, R, 0);
      wait_pops(9);
      sensor = 1'b0;
      push(8, R, G, 0); push(3, R, Y, 0); push(8, G, R, 0);
      wait_pops(12);

      // 3: walk request pulse mid main green
      repeat (3) @(posedge clock);
      #1 walk_request = 1'b1;
      @(posedge clock); #1 walk_request = 1'b0;
      push(3, Y, R, 0); push(10, R, R, 1); push(8, G, R, 0); push(8, G, R, 0);
      wait_pops(16);

      // 6: walk request held through the whole walk phase
      repeat (2) @(posedge clock);
      #1 walk_request = 1'b1;
      @(posedge clock); #1 walk_request = 1'b0;
      push(3, Y, R, 0); push(10, R, R, 1);
      wait_pops(18);
      walk_request = 1'b1;
      count_to_load(n);
      walk_request = 1'b0;
      chk("ped_exit_seen", start_timer, 1);
      push(8, G, R, 0); push(8, G, R, 0);
      wait_pops(20);

      // 4: expired forced high through LOAD and ARM
      ovr = 1'b1;
      push(8, G, R, 0); push(8, G, R, 0);
      count_to_load(n);
      chk("ovr_arm_to_load", n, 2);
      count_to_load(n);
      chk("ovr_load_to_load", n, 3);
      ovr = 1'b0;
      wait_pops(22);

      // 5: async reset mid side green
      sensor = 1'b1;
      push(3, Y, R, 0); push(12, R, G, 0);
      wait_pops(24);
      sensor = 1'b0;
      repeat (4) @(posedge clock);
      #3 reset = 1'b0;
      #1;
      chk("arst_main",  main_light,  R);
      chk("arst_side",  side_light,  R);
      chk("arst_walk",  walk,        0);
      chk("arst_start", start_timer, 0);
      chk("arst_value", value,       0);
      @(negedge clock);
      push(8, G, R, 0); push(8, G, R, 0);
      #2 reset = 1'b1;
      wait_pops(26);

      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
